prog_loader: RTL and testbench

- Writer end of the CPU's 16x4 program memory. Accepts a framed nibble stream from a host over a valid/ready handshake and writes it into program memory through a single write port.
- Zero-fills all unused addresses so they decode as NOP.
- Holds the CPU in reset while loading. Releases the CPU only after a frame with a good checksum has been written completely.

---
 rtl/prog_loader_if.sv | 24 ++
 rtl/prog_loader.sv | 191 +++++++++++++++++++
 tb/tb_prog_loader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Host-side nibble stream plus program-memory write port and CPU control for prog_loader.
interface prog_loader_if;
    logic       start;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [3:0] mem_wdata;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a framed nibble stream (LEN, data, CSUM) into a 16x4 program memory,
// zero-fills the tail and releases the CPU only after a verified, complete load.
module prog_loader #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave ldr
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_FILL = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    // Counter only needs to hold TIMEOUT-1: the hit fires on the idle cycle that would reach TIMEOUT.
    localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [4:0]      FULL_N   = 5'(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [4:0]    n_q, n_d;
    logic [4:0]    addr_q, addr_d;
    logic [3:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          in_ready_q, in_ready_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_addr_q, mem_addr_d;
    logic [3:0]    mem_wdata_q, mem_wdata_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic xfer;
    logic receiving;
    logic tmo_hit;

    assign xfer      = ldr.in_valid & in_ready_q;
    assign receiving = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        tmo_d       = tmo_q;
        in_ready_d  = in_ready_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        tmo_hit     = 1'b0;

        if (receiving) begin
            if (xfer) begin
                tmo_d = '0;
            end else begin
                tmo_d   = tmo_q + 1'b1;
                tmo_hit = (TIMEOUT > 0) && (tmo_q == TMO_LAST);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (ldr.start) begin
                    state_d     = S_LEN;
                    busy_d      = 1'b1;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    in_ready_d  = 1'b1;
                    tmo_d       = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    n_d     = (ldr.in_data == 4'd0) ? FULL_N : {1'b0, ldr.in_data};
                    addr_d  = 5'd0;
                    sum_d   = 4'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[3:0];
                    mem_wdata_d = ldr.in_data;
                    sum_d       = sum_q + ldr.in_data;
                    addr_d      = addr_q + 5'd1;
                    if (addr_q == n_q - 5'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    in_ready_d = 1'b0;
                    if (ldr.in_data == sum_q) begin
                        if (n_q < FULL_N) begin
                            // First fill write is issued here so FILL spends exactly 16-N cycles writing.
                            state_d     = S_FILL;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = n_q[3:0];
                            mem_wdata_d = 4'd0;
                            addr_d      = n_q + 5'd1;
                        end else begin
                            state_d = S_FIN;
                        end
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            S_FILL: begin
                if (addr_q == FULL_N) begin
                    state_d = S_FIN;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[3:0];
                    mem_wdata_d = 4'd0;
                    addr_d      = addr_q + 5'd1;
                end
            end
            S_FIN: begin
                state_d     = S_IDLE;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                cpu_reset_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tmo_hit) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            busy_d     = 1'b0;
            in_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= 5'd0;
            addr_q      <= 5'd0;
            sum_q       <= 4'd0;
            tmo_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 4'd0;
            mem_wdata_q <= 4'd0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ldr.in_ready  = in_ready_q;
    assign ldr.mem_we    = mem_we_q;
    assign ldr.mem_addr  = mem_addr_q;
    assign ldr.mem_wdata = mem_wdata_q;
    assign ldr.cpu_reset = cpu_reset_q;
    assign ldr.busy      = busy_q;
    assign ldr.done      = done_q;
    assign ldr.err       = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected memory writes, a negedge monitor checks them.
module tb_prog_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q[$];

    prog_loader_if bus();

    prog_loader #(.DEPTH(16), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .ldr   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_w(input int addr, input logic [3:0] data);
        exp_q.push_back({addr[3:0], data});
    endtask

    // Write monitor: every mem_we cycle must match the next expected (addr,data) pair.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            $display("write addr=%0d data=%0h", bus.mem_addr, bus.mem_wdata);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h, expected no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                chk("write_addr_data", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic send(input logic [3:0] d, input int gap, input logic exp_we);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (bus.in_ready !== 1'b1) begin
            w++;
            if (w > 20) begin
                checks++;
                errors++;
                $display("FAIL ready_wait: got in_ready=%0b for 20 cycles, expected 1", bus.in_ready);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (g == 0) chk("we_after_xfer", {7'd0, bus.mem_we}, {7'd0, exp_we});
            if (g == 1) chk("we_after_gap", {7'd0, bus.mem_we}, 8'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [3:0] len, input logic [63:0] data, input logic [3:0] csum,
                        input int gap, input bit good);
        int n;
        int cnt;
        n = (len == 4'd0) ? 16 : int'(len);
        for (int i = 0; i < n; i++) push_w(i, data[4*i +: 4]);
        if (good) for (int a = n; a < 16; a++) push_w(a, 4'd0);
        do_start();
        send(len, gap, 1'b0);
        for (int i = 0; i < n; i++) send(data[4*i +: 4], gap, 1'b1);
        send(csum, 0, 1'b0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.busy === 1'b1 && cnt < 100);
        chk("cycles_to_end", 8'(cnt), good ? 8'(16 - n + 2) : 8'd1);
        chk("done", {7'd0, bus.done}, {7'd0, good});
        chk("err", {7'd0, bus.err}, {7'd0, !good});
        chk("cpu_reset", {7'd0, bus.cpu_reset}, {7'd0, !good});
        chk("busy_end", {7'd0, bus.busy}, 8'd0);
        chk("in_ready_end", {7'd0, bus.in_ready}, 8'd0);
        $display("frame len=%0d good=%0b gap=%0d done=%0b err=%0b", len, good, gap, bus.done, bus.err);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {7'd0, bus.in_ready}, 8'd0);
        chk({tag, "_mem_we"}, {7'd0, bus.mem_we}, 8'd0);
        chk({tag, "_mem_addr"}, {4'd0, bus.mem_addr}, 8'd0);
        chk({tag, "_mem_wdata"}, {4'd0, bus.mem_wdata}, 8'd0);
        chk({tag, "_cpu_reset"}, {7'd0, bus.cpu_reset}, 8'd1);
        chk({tag, "_busy"}, {7'd0, bus.busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, bus.done}, 8'd0);
        chk({tag, "_err"}, {7'd0, bus.err}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish after 200000 time units, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        load(4'd3, 64'h321, 4'd6, 0, 1'b1);
        load(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 0, 1'b1);
        load(4'd2, 64'h54, 4'd0, 0, 1'b0);
        load(4'd3, 64'h321, 4'd6, 2, 1'b1);

        // Timeout: after the last transfer, err must appear on the fifth observed cycle.
        push_w(0, 4'h9);
        do_start();
        send(4'd5, 0, 1'b0);
        send(4'h9, 0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("tmo_err_early", {7'd0, bus.err}, 8'd0);
            chk("tmo_busy_early", {7'd0, bus.busy}, 8'd1);
        end
        @(negedge clk);
        chk("tmo_err", {7'd0, bus.err}, 8'd1);
        chk("tmo_busy", {7'd0, bus.busy}, 8'd0);
        chk("tmo_cpu_reset", {7'd0, bus.cpu_reset}, 8'd1);
        chk("tmo_in_ready", {7'd0, bus.in_ready}, 8'd0);
        $display("timeout err=%0b busy=%0b", bus.err, bus.busy);
        @(posedge clk);
        #1;

        // Reset mid-DATA, asserted in the cycle that presents the second write.
        push_w(0, 4'hA);
        push_w(1, 4'hB);
        do_start();
        send(4'd5, 0, 1'b0);
        send(4'hA, 0, 1'b1);
        send(4'hB, 0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");
        $display("mid-frame reset applied");
        @(posedge clk);
        #1;
        load(4'd1, 64'h7, 4'd7, 0, 1'b1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
